// File: rtl/fifo_rd_stream.sv
// Pops a synchronous FIFO with one-cycle read latency and presents the words as a valid/ready stream.
// A 2-entry skid buffer absorbs the pop-to-data latency so the stream sustains one word per cycle.
//
// state | meaning
// ------+------------------------------------------------------------
// INIT  | startup lockout after reset, no pops while the FIFO recovers
// RUN   | normal streaming
// FLUSH | one-cycle hold after flush, FIFO flush still settling
module fifo_rd_stream #(
    parameter int DATA_WIDTH     = 32,
    parameter int STARTUP_CYCLES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  fifo_empty_i,
    input  logic [DATA_WIDTH-1:0] fifo_data_i,
    output logic                  fifo_pop_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [1:0]            count_o,
    output logic                  init_done_o
);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [7:0] INIT_LAST = 8'(STARTUP_CYCLES - 1);

    state_t                state_q;
    state_t                state_d;
    logic [7:0]            init_cnt_q;
    logic [1:0]            occ_q;
    logic                  inflight_q;
    logic [DATA_WIDTH-1:0] buf0_q;
    logic [DATA_WIDTH-1:0] buf1_q;

    logic                  flush_act;
    logic                  deq;
    logic                  capture;
    logic [1:0]            pending;

    // flush has no effect during the startup lockout
    assign flush_act = flush_i && (state_q != ST_INIT);
    assign deq       = valid_o && ready_i;
    assign capture   = inflight_q && !flush_act;
    assign pending   = occ_q + {1'b0, inflight_q};

    assign valid_o     = (occ_q != 2'd0);
    assign data_o      = buf0_q;
    assign count_o     = occ_q;
    assign init_done_o = (state_q != ST_INIT);

    always_comb begin
        state_d    = state_q;
        fifo_pop_o = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (init_cnt_q == INIT_LAST) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (flush_i) begin
                    state_d = ST_FLUSH;
                end else if (!fifo_empty_i) begin
                    // a pop is only safe if its word has a slot when it lands
                    fifo_pop_o = (pending < 2'd2) || ((pending == 2'd2) && deq);
                end
            end
            ST_FLUSH: begin
                if (!flush_i) state_d = ST_RUN;
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_INIT;
            init_cnt_q <= 8'd0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= fifo_pop_o;
            if (state_q == ST_INIT) init_cnt_q <= init_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occ_q  <= 2'd0;
            buf0_q <= '0;
            buf1_q <= '0;
        end else if (flush_act) begin
            occ_q <= 2'd0;
        end else begin
            occ_q <= occ_q + {1'b0, capture} - {1'b0, deq};
            case (occ_q)
                2'd0: begin
                    if (capture) buf0_q <= fifo_data_i;
                end
                2'd1: begin
                    if (capture && deq)  buf0_q <= fifo_data_i;
                    else if (capture)    buf1_q <= fifo_data_i;
                end
                2'd2: begin
                    if (deq)     buf0_q <= buf1_q;
                    if (capture) buf1_q <= fifo_data_i;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: startup lockout, streaming, backpressure, empty boundary,
// flush and mid-stream reset, against a behavioural one-cycle-latency FIFO.
module tb_fifo_rd_stream;

    logic        clk_i;
    logic        rst_ni;
    logic        flush_i;
    logic        fifo_empty_i;
    logic [31:0] fifo_data_i;
    logic        fifo_pop_o;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] data_o;
    logic [1:0]  count_o;
    logic        init_done_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] fifo_mem [0:63];
    int          wr_cnt = 0;
    int          rd_cnt = 0;

    fifo_rd_stream #(.DATA_WIDTH(32), .STARTUP_CYCLES(16)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .fifo_empty_i(fifo_empty_i),
        .fifo_data_i (fifo_data_i),
        .fifo_pop_o  (fifo_pop_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .data_o      (data_o),
        .count_o     (count_o),
        .init_done_o (init_done_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // synchronous FIFO: read data one cycle after pop, flush registered on the same flush_i
    assign fifo_empty_i = (wr_cnt == rd_cnt);
    always @(posedge clk_i) begin
        if (flush_i) begin
            rd_cnt <= wr_cnt;
        end else if (fifo_pop_o) begin
            fifo_data_i <= fifo_mem[rd_cnt[5:0]];
            rd_cnt      <= rd_cnt + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push(input logic [31:0] v);
        fifo_mem[wr_cnt[5:0]] = v;
        wr_cnt = wr_cnt + 1;
    endtask

    task automatic step();
        @(negedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        rst_ni  = 1'b0;
        flush_i = 1'b0;
        ready_i = 1'b0;
        fifo_data_i = 32'h0;
        step();
        step();
        n_cmp++; if (fifo_pop_o !== 1'b0) begin n_bad++; $display("FAIL reset_pop: got %b want 0", fifo_pop_o); end
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        n_cmp++; if (count_o !== 2'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", count_o); end
        n_cmp++; if (init_done_o !== 1'b0) begin n_bad++; $display("FAIL reset_init_done: got %b want 0", init_done_o); end
    endtask

    task automatic test_startup_stream();
        int first_pop = -1;
        int init_rise = -1;
        int first_valid = -1;
        int pops = 0;
        int n_acc = 0;
        bit gap_err = 0;
        for (int i = 1; i <= 8; i++) push(32'(i));
        ready_i = 1'b1;
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        for (int cyc = 0; cyc < 40; cyc++) begin
            if (fifo_pop_o) begin
                if (first_pop < 0) first_pop = cyc;
                pops++;
            end
            if (init_done_o && init_rise < 0) init_rise = cyc;
            if (valid_o && ready_i) begin
                if (first_valid < 0) first_valid = cyc;
                if (cyc != first_valid + n_acc) gap_err = 1;
                n_cmp++;
                if (data_o !== 32'(n_acc + 1)) begin
                    n_bad++;
                    $display("FAIL stream_word%0d: got %h want %h", n_acc, data_o, n_acc + 1);
                end
                n_acc++;
            end
            step();
        end
        n_cmp++; if (first_pop != 16) begin n_bad++; $display("FAIL startup_first_pop: got cycle %0d want 16", first_pop); end
        n_cmp++; if (init_rise != 16) begin n_bad++; $display("FAIL startup_init_done: got cycle %0d want 16", init_rise); end
        n_cmp++; if (first_valid != 18) begin n_bad++; $display("FAIL stream_first_valid: got cycle %0d want 18", first_valid); end
        n_cmp++; if (pops != 8) begin n_bad++; $display("FAIL stream_pops: got %0d want 8", pops); end
        n_cmp++; if (n_acc != 8) begin n_bad++; $display("FAIL stream_count: got %0d want 8", n_acc); end
        n_cmp++; if (gap_err) begin n_bad++; $display("FAIL stream_consecutive: got gap want none"); end
    endtask

    task automatic test_backpressure();
        int pops = 0;
        int n_acc = 0;
        int guard = 0;
        bit stable_err = 0;
        logic [31:0] acc [0:3];
        ready_i = 1'b0;
        for (int i = 0; i < 4; i++) push(32'h11 + 32'(i));
        #1;
        for (int i = 0; i < 6; i++) begin
            if (fifo_pop_o) pops++;
            if (i >= 3 && (valid_o !== 1'b1 || data_o !== 32'h11)) stable_err = 1;
            step();
        end
        n_cmp++; if (pops != 2) begin n_bad++; $display("FAIL bp_pops: got %0d want 2", pops); end
        n_cmp++; if (count_o !== 2'd2) begin n_bad++; $display("FAIL bp_count: got %0d want 2", count_o); end
        n_cmp++; if (stable_err) begin n_bad++; $display("FAIL bp_hold: got valid=%b data=%h want valid=1 data=11", valid_o, data_o); end
        ready_i = 1'b1;
        #1;
        while (n_acc < 4 && guard < 12) begin
            if (valid_o && ready_i) begin
                acc[n_acc] = data_o;
                n_acc++;
            end
            guard++;
            step();
        end
        n_cmp++; if (n_acc != 4) begin n_bad++; $display("FAIL bp_drain_count: got %0d want 4", n_acc); end
        for (int i = 0; i < n_acc; i++) begin
            n_cmp++;
            if (acc[i] !== 32'h11 + 32'(i)) begin
                n_bad++;
                $display("FAIL bp_order%0d: got %h want %h", i, acc[i], 32'h11 + 32'(i));
            end
        end
        n_cmp++; if (count_o !== 2'd0) begin n_bad++; $display("FAIL bp_final_count: got %0d want 0", count_o); end
    endtask

    task automatic test_empty();
        int pops = 0;
        int n_acc = 0;
        bit pop_on_empty = 0;
        logic [31:0] got = 32'h0;
        ready_i = 1'b1;
        push(32'h55);
        #1;
        for (int i = 0; i < 6; i++) begin
            if (fifo_pop_o) pops++;
            if (fifo_empty_i && fifo_pop_o) pop_on_empty = 1;
            if (valid_o && ready_i) begin
                got = data_o;
                n_acc++;
            end
            step();
        end
        n_cmp++; if (pops != 1) begin n_bad++; $display("FAIL empty_pops: got %0d want 1", pops); end
        n_cmp++; if (pop_on_empty) begin n_bad++; $display("FAIL empty_pop_while_empty: got pop want none"); end
        n_cmp++; if (n_acc != 1 || got !== 32'h55) begin n_bad++; $display("FAIL empty_word: got %0d words last %h want 1 word 55", n_acc, got); end
        n_cmp++; if (count_o !== 2'd0) begin n_bad++; $display("FAIL empty_final_count: got %0d want 0", count_o); end
    endtask

    task automatic test_flush();
        int n_acc = 0;
        logic [31:0] acc [0:7];
        ready_i = 1'b0;
        for (int i = 0; i < 4; i++) push(32'h21 + 32'(i));
        #1;
        step();
        step();
        // one word buffered, a second in flight
        n_cmp++; if (count_o !== 2'd1) begin n_bad++; $display("FAIL flush_pre_count: got %0d want 1", count_o); end
        flush_i = 1'b1;
        #1;
        n_cmp++; if (fifo_pop_o !== 1'b0) begin n_bad++; $display("FAIL flush_pop_same: got %b want 0", fifo_pop_o); end
        @(negedge clk_i);
        flush_i = 1'b0;
        push(32'h31);
        push(32'h32);
        #1;
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL flush_valid: got %b want 0", valid_o); end
        n_cmp++; if (count_o !== 2'd0) begin n_bad++; $display("FAIL flush_count: got %0d want 0", count_o); end
        n_cmp++; if (fifo_pop_o !== 1'b0) begin n_bad++; $display("FAIL flush_pop_next: got %b want 0", fifo_pop_o); end
        n_cmp++; if (init_done_o !== 1'b1) begin n_bad++; $display("FAIL flush_init_done: got %b want 1", init_done_o); end
        ready_i = 1'b1;
        step();
        n_cmp++; if (fifo_pop_o !== 1'b1) begin n_bad++; $display("FAIL flush_resume_pop: got %b want 1", fifo_pop_o); end
        for (int i = 0; i < 8; i++) begin
            if (valid_o && ready_i && n_acc < 8) begin
                acc[n_acc] = data_o;
                n_acc++;
            end
            step();
        end
        n_cmp++; if (n_acc != 2) begin n_bad++; $display("FAIL flush_after_count: got %0d want 2", n_acc); end
        for (int i = 0; i < n_acc && i < 2; i++) begin
            n_cmp++;
            if (acc[i] !== 32'h31 + 32'(i)) begin
                n_bad++;
                $display("FAIL flush_after_word%0d: got %h want %h", i, acc[i], 32'h31 + 32'(i));
            end
        end
    endtask

    task automatic test_reset_midstream();
        int first_pop = -1;
        for (int i = 0; i < 8; i++) push(32'h41 + 32'(i));
        ready_i = 1'b1;
        #1;
        step();
        step();
        step();
        n_cmp++; if (valid_o !== 1'b1) begin n_bad++; $display("FAIL mid_streaming: got valid=%b want 1", valid_o); end
        #2;
        rst_ni = 1'b0;
        #1;
        n_cmp++; if (fifo_pop_o !== 1'b0) begin n_bad++; $display("FAIL mid_rst_pop: got %b want 0", fifo_pop_o); end
        n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL mid_rst_valid: got %b want 0", valid_o); end
        n_cmp++; if (count_o !== 2'd0) begin n_bad++; $display("FAIL mid_rst_count: got %0d want 0", count_o); end
        n_cmp++; if (init_done_o !== 1'b0) begin n_bad++; $display("FAIL mid_rst_init_done: got %b want 0", init_done_o); end
        @(negedge clk_i);
        rst_ni = 1'b1;
        #1;
        for (int cyc = 0; cyc < 40 && first_pop < 0; cyc++) begin
            if (fifo_pop_o) begin
                first_pop = cyc;
                n_cmp++;
                if (init_done_o !== 1'b1) begin n_bad++; $display("FAIL mid_init_done_at_pop: got %b want 1", init_done_o); end
            end else begin
                step();
            end
        end
        n_cmp++; if (first_pop != 16) begin n_bad++; $display("FAIL mid_reinit_first_pop: got cycle %0d want 16", first_pop); end
    endtask

    initial begin
        test_reset();
        test_startup_stream();
        test_backpressure();
        test_empty();
        test_flush();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
